// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and the default
// address/instruction widths that decode and the ALU stage also use.
package fetch_pkg;

    localparam int PC_W_DEF    = 16;
    localparam int INSTR_W_DEF = 9;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        DROP,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small power-of-two FIFO holding {instruction, pc} pairs between fetch and decode.
// Flush wins over push; head reads as zero while empty.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!flush && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, the imem req/ack handshake and the
// branch redirect/flush, and feeds decode through fetch_buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               branch_en,
    input  logic               compres,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               halt,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t      state, state_n;
    logic [PC_W-1:0]   fetch_pc, fetch_pc_n;
    logic [PC_W-1:0]   addr_n;
    logic              req_n;
    logic              taken;
    logic              ack;
    logic              buf_push;
    logic              buf_pop;
    logic              buf_full;
    logic              buf_empty;
    logic [CW-1:0]     buf_count;
    logic [CW-1:0]     cnt_after;
    logic [PC_W-1:0]   next_seq;

    assign taken       = branch_en && compres;
    assign ack         = imem_req && imem_ack;
    assign instr_valid = !buf_empty && !taken;
    assign buf_pop     = instr_valid && instr_ready;
    assign buf_push    = (state == WAIT) && ack && !taken;
    assign cnt_after   = buf_count + CW'(1) - CW'(buf_pop);
    assign next_seq    = imem_addr + PC_W'(1);

    fetch_buffer #(
        .WIDTH (INSTR_W + PC_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clock (clock),
        .reset (reset),
        .flush (taken),
        .push  (buf_push),
        .pop   (buf_pop),
        .din   ({imem_data, imem_addr}),
        .dout  ({instr_out, instr_pc}),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            fetch_pc  <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
        end
    end

    // A taken branch always retargets fetch_pc; each state decides when the
    // handshake may act on it, since an outstanding request is never aborted.
    always_comb begin
        state_n    = state;
        fetch_pc_n = taken ? branch_target : fetch_pc;
        req_n      = imem_req;
        addr_n     = imem_addr;
        case (state)
            RUN: begin
                if (halt) begin
                    state_n = HALTED;
                end else if (taken || !buf_full || buf_pop) begin
                    req_n   = 1'b1;
                    addr_n  = fetch_pc_n;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (ack) begin
                    if (!taken) fetch_pc_n = next_seq;
                    if (halt) begin
                        req_n   = 1'b0;
                        state_n = HALTED;
                    end else if (taken || (cnt_after < CW'(BUF_DEPTH))) begin
                        req_n  = 1'b1;
                        addr_n = fetch_pc_n;
                    end else begin
                        req_n   = 1'b0;
                        state_n = RUN;
                    end
                end else if (taken) begin
                    state_n = DROP;
                end
            end
            DROP: begin
                if (ack) begin
                    if (halt) begin
                        req_n   = 1'b0;
                        state_n = HALTED;
                    end else begin
                        req_n   = 1'b1;
                        addr_n  = fetch_pc_n;
                        state_n = WAIT;
                    end
                end
            end
            HALTED: begin
                if (!halt) state_n = RUN;
            end
            default: state_n = RUN;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable memory model answers
// requests, and a scoreboard queue holds the pcs decode is expected to receive.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [8:0]  imem_data;
    logic        branch_en;
    logic        compres;
    logic [15:0] branch_target;
    logic        halt;
    logic        instr_valid;
    logic [8:0]  instr_out;
    logic [15:0] instr_pc;
    logic        instr_ready;

    int          checks;
    int          failures;
    int          lat;
    int          wcnt;
    logic        stray_ack;
    logic [15:0] sb_q[$];

    fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .branch_en     (branch_en),
        .compres       (compres),
        .branch_target (branch_target),
        .halt          (halt),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: memory answers, the handoff is scored, then the edge.
    task automatic applyStimulus();
        logic        r;
        logic        a;
        logic [15:0] exp_pc;
        imem_ack  = stray_ack || (imem_req && (wcnt >= lat));
        imem_data = stray_ack ? 9'h1AB : imem_addr[8:0];
        #1;
        if (instr_valid && instr_ready) begin
            checkOutput("sb_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_pc = sb_q.pop_front();
                checkOutput("sb_pc", 32'(instr_pc), 32'(exp_pc));
                checkOutput("sb_instr", 32'(instr_out), 32'(exp_pc[8:0]));
            end
        end
        r = imem_req;
        a = imem_ack;
        @(posedge clock);
        #1;
        wcnt = (r && !a) ? wcnt + 1 : 0;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic runUntilEmpty(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < max_cycles) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic doReset(input int latency);
        reset         = 1'b1;
        branch_en     = 1'b0;
        compres       = 1'b0;
        branch_target = '0;
        halt          = 1'b0;
        instr_ready   = 1'b1;
        stray_ack     = 1'b0;
        imem_ack      = 1'b0;
        imem_data     = '0;
        lat           = latency;
        wcnt          = 0;
        sb_q.delete();
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        stray_ack = 1'b0;
        lat       = 0;
        wcnt      = 0;

        // Reset values and first request.
        doReset(0);
        reset = 1'b1;
        #1;
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr", 32'(instr_out), 32'd0);
        checkOutput("rst_pc", 32'(instr_pc), 32'd0);
        reset = 1'b0;

        // Zero-wait streaming: pcs 0..3 on consecutive cycles.
        for (int i = 0; i < 4; i++) sb_q.push_back(16'(i));
        applyStimulus();
        checkOutput("t1_first_req", 32'(imem_req), 32'd1);
        checkOutput("t1_first_addr", 32'(imem_addr), 32'd0);
        applyStimulus();
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_valid_cont", 32'(instr_valid), 32'd1);
            applyStimulus();
        end
        checkOutput("t1_drain", 32'(sb_q.size()), 32'd0);

        // Decode stalled: buffer fills with pc 0,1 and fetch stops.
        doReset(0);
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) sb_q.push_back(16'(i));
        runCycles(6);
        checkOutput("t2_req_low", 32'(imem_req), 32'd0);
        checkOutput("t2_head_pc", 32'(instr_pc), 32'd0);
        checkOutput("t2_head_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        applyStimulus();
        checkOutput("t2_resume_req", 32'(imem_req), 32'd1);
        checkOutput("t2_resume_addr", 32'(imem_addr), 32'd2);
        runUntilEmpty("t2_drain", 20);

        // Slow memory, taken branch during the fetch of 0x0005.
        doReset(2);
        for (int i = 0; i < 5; i++) sb_q.push_back(16'(i));
        runCycles(17);
        checkOutput("t3_pending_addr", 32'(imem_addr), 32'h5);
        checkOutput("t3_buf_empty", 32'(sb_q.size()), 32'd0);
        branch_en     = 1'b1;
        compres       = 1'b1;
        branch_target = 16'h0040;
        applyStimulus();
        branch_en = 1'b0;
        compres   = 1'b0;
        checkOutput("t3_req_held", 32'(imem_req), 32'd1);
        checkOutput("t3_addr_held", 32'(imem_addr), 32'h5);
        checkOutput("t3_flushed", 32'(instr_valid), 32'd0);
        applyStimulus();
        checkOutput("t3_redirect_addr", 32'(imem_addr), 32'h40);
        checkOutput("t3_still_empty", 32'(instr_valid), 32'd0);
        sb_q.push_back(16'h0040);
        sb_q.push_back(16'h0041);
        runUntilEmpty("t3_drain", 30);

        // Not-taken branch is ignored; taken branch with ack and ready drops data.
        doReset(0);
        sb_q.push_back(16'h0000);
        runCycles(2);
        branch_en     = 1'b1;
        compres       = 1'b0;
        branch_target = 16'h0200;
        applyStimulus();
        checkOutput("t4_nt_addr", 32'(imem_addr), 32'h2);
        compres       = 1'b1;
        branch_target = 16'h0100;
        #1;
        checkOutput("t4_taken_valid", 32'(instr_valid), 32'd0);
        applyStimulus();
        branch_en = 1'b0;
        compres   = 1'b0;
        checkOutput("t4_redirect_addr", 32'(imem_addr), 32'h100);
        sb_q.push_back(16'h0100);
        sb_q.push_back(16'h0101);
        runUntilEmpty("t4_drain", 10);

        // Branch to the top of the address space wraps to zero.
        doReset(0);
        runCycles(1);
        branch_en     = 1'b1;
        compres       = 1'b1;
        branch_target = 16'hFFFF;
        applyStimulus();
        branch_en = 1'b0;
        compres   = 1'b0;
        sb_q.push_back(16'hFFFF);
        sb_q.push_back(16'h0000);
        sb_q.push_back(16'h0001);
        runUntilEmpty("t5_drain", 10);

        // Halt during an outstanding fetch: it completes, then no more requests.
        doReset(2);
        runCycles(1);
        halt = 1'b1;
        sb_q.push_back(16'h0000);
        runCycles(3);
        checkOutput("t6_req_dropped", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t6_req_low", 32'(imem_req), 32'd0);
        end
        checkOutput("t6_delivered", 32'(sb_q.size()), 32'd0);
        halt = 1'b0;
        runCycles(2);
        checkOutput("t6_resume_req", 32'(imem_req), 32'd1);
        checkOutput("t6_resume_addr", 32'(imem_addr), 32'd1);

        // Asynchronous reset mid-wait, then a stray ack while req is low.
        doReset(2);
        runCycles(2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t7_async_req", 32'(imem_req), 32'd0);
        checkOutput("t7_async_addr", 32'(imem_addr), 32'd0);
        #1;
        reset     = 1'b0;
        lat       = 0;
        wcnt      = 0;
        stray_ack = 1'b1;
        applyStimulus();
        stray_ack = 1'b0;
        checkOutput("t7_restart_req", 32'(imem_req), 32'd1);
        checkOutput("t7_restart_addr", 32'(imem_addr), 32'd0);
        checkOutput("t7_stray_ignored", 32'(instr_valid), 32'd0);
        sb_q.push_back(16'h0000);
        sb_q.push_back(16'h0001);
        runUntilEmpty("t7_drain", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-issue 16-bit core. It holds the program counter and issues requests to instruction memory over a req/ack handshake. It buffers returned instructions in a small FIFO for decode. It consumes the branch compare result produced by the ALU stage, redirecting and flushing on a taken branch.

## Interface
Parameters:
- PC_W, 16, program counter / instruction address width
- INSTR_W, 9, instruction word width
- BUF_DEPTH, 2, instruction buffer entries (power of two, ≥2)

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- imem_req  out  1  fetch request, registered
- imem_addr  out  PC_W  fetch address, registered, stable while imem_req=1
- imem_ack  in  1  memory response; imem_data valid this cycle; sampled only while imem_req=1
- imem_data  in  INSTR_W  fetched instruction
- branch_en  in  1  ALU stage holds a branch op this cycle
- compres  in  1  ALU compare result; taken = branch_en & compres
- branch_target  in  PC_W  redirect address, valid when branch_en=1
- halt  in  1  level; stop issuing new fetches
- instr_valid  out  1  buffer head valid for decode
- instr_out  out  INSTR_W  buffer head instruction
- instr_pc  out  PC_W  address of instr_out
- instr_ready  in  1  decode accepts head this cycle

## Operation
- FSM states: RUN, WAIT (request outstanding), DROP (outstanding request whose data is to be discarded), HALTED.
- Reset values:
  - fetch_pc=0; state=RUN; imem_req=0; imem_addr=0; buffer empty; instr_valid=0.
  - instr_out and instr_pc read 0 when empty.
- RUN: if !halt and buffer has room, assert imem_req with imem_addr=fetch_pc, then go to WAIT.
- WAIT, on ack:
  - Push {imem_data, imem_addr} into the buffer; fetch_pc = imem_addr+1, modulo 2^PC_W, so 0xFFFF wraps to 0x0000.
  - If room remains (count after this push and any same-cycle pop < BUF_DEPTH) and !halt, keep imem_req=1 with the new address. Otherwise drop req and go to RUN, or to HALTED if halt=1.
- Only one request is ever outstanding. A request is never aborted: req stays high until ack.
- Taken branch, in any state:
  - Flush the buffer and set fetch_pc=branch_target.
  - If a request is outstanding and not acked this cycle, go to DROP.
  - If acked in the same cycle, discard that data and continue from branch_target.
  - instr_valid is forced 0 in the taken cycle, so no handoff occurs.
- Not-taken branch (branch_en=1, compres=0): no effect.
- DROP: hold req until ack, discard the data, then issue branch_target. This applies the most recent target if further taken branches arrived meanwhile.
- Halt:
  - An outstanding fetch completes and is buffered; the block then enters HALTED with req=0.
  - The buffer still drains to decode.
  - A taken branch while HALTED updates fetch_pc and flushes.
  - halt deasserted → RUN.
- Pop: instr_valid & instr_ready advances the head. Push and pop may occur in the same cycle when full; the count stays unchanged.
- Acks with imem_req=0 are ignored.

## Timing
- First request: imem_req=1, addr=0 in the first cycle after reset deasserts (first rising edge).
- Latency:
  - Ack in cycle N → instr_valid=1 in cycle N+1.
  - With a zero-wait memory (ack in the same cycle as req) and instr_ready=1 held, throughput is 1 instruction/cycle.
- Taken branch in cycle N:
  - imem_addr=branch_target in cycle N+1 if no request was outstanding, or if it was acked in N.
  - Otherwise, the cycle after the DROP ack.
- Reset asserted mid-fetch: outputs go to reset values immediately (asynchronous). A stale ack after reset is ignored because req=0.

## Structure
- Package fetch_pkg: state enum (RUN, WAIT, DROP, HALTED) and default PC_W/INSTR_W constants shared with decode and ALU.
- Sub-module fetch_buffer: BUF_DEPTH-entry FIFO of {INSTR_W+PC_W} with push, pop, synchronous flush, count, full, empty. Flush has priority over push.
- fetch_unit owns the FSM, the PC, and the handshake.

## Test plan
- Reset, then zero-wait memory returning addr as data, instr_ready=1 → instr_pc 0,1,2,3 on consecutive cycles, instr_valid continuous.
- instr_ready=0 for 5 cycles → exactly 2 entries (pc 0,1) buffered, imem_req low, no address skipped; on release, pc 2 fetched next.
- Memory with 3-cycle ack; taken branch to 0x0040 in the second cycle of the fetch of 0x0005 → ack data for 0x0005 discarded, next imem_addr=0x0040, buffer empty in between.
- Taken branch in the same cycle as an ack and as instr_ready=1 → instr_valid=0 that cycle, acked data dropped, next instr_pc=branch_target. A not-taken branch (compres=0) changes nothing.
- branch_target=0xFFFF → instr_pc 0xFFFF then 0x0000.
- halt raised during an outstanding fetch → that instruction delivered, imem_req stays 0. Asynchronous reset mid-wait → imem_req=0 immediately; a later stray ack is ignored and fetch restarts at 0.
